// File: rtl/krz_gpio.sv
// KRZ SoC GPIO: N bidirectional pins with per-pin direction and output registers,
// synchronised inputs, rise/fall edge interrupts and a hardware blink generator.
module krz_gpio #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int BLINK_W     = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bus_req,
    input  logic             bus_we,
    input  logic [2:0]       bus_addr,
    input  logic [3:0]       bus_mask,
    input  logic [31:0]      bus_wr_data,
    output logic [31:0]      bus_rd_data,
    output logic             bus_ack,
    input  logic [N-1:0]     gpio_in,
    output logic [N-1:0]     gpio_out,
    output logic [N-1:0]     gpio_oe,
    output logic             irq
);

    localparam logic [2:0] A_DIR    = 3'd0;
    localparam logic [2:0] A_OUT    = 3'd1;
    localparam logic [2:0] A_IN     = 3'd2;
    localparam logic [2:0] A_RISE   = 3'd3;
    localparam logic [2:0] A_FALL   = 3'd4;
    localparam logic [2:0] A_PEND   = 3'd5;
    localparam logic [2:0] A_BLINK  = 3'd6;
    localparam logic [2:0] A_PERIOD = 3'd7;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
        return (old & ~be_mask(be)) | (wd & be_mask(be));
    endfunction

    logic [N-1:0]       dir_q, out_q, rise_en_q, fall_en_q, pend_q, blink_en_q;
    logic [BLINK_W-1:0] period_q, cnt_q;
    logic               phase_q;
    logic [N-1:0]       in_sync [SYNC_STAGES];
    logic [N-1:0]       in_p0, in_p1;
    logic [N-1:0]       pend_set, pend_clr;
    logic [31:0]        rd_mux;
    logic               wr;

    assign wr      = bus_req & bus_we;
    assign gpio_oe = dir_q;
    assign in_p0   = in_sync[SYNC_STAGES-1];

    // Edge detect on the synchronised value against its previous-cycle copy
    assign pend_set = (in_p0 & ~in_p1 & rise_en_q) | (~in_p0 & in_p1 & fall_en_q);
    assign pend_clr = (wr && bus_addr == A_PEND) ? N'(bus_wr_data & be_mask(bus_mask)) : '0;

    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            A_DIR:    rd_mux = 32'(dir_q);
            A_OUT:    rd_mux = 32'(out_q);
            A_IN:     rd_mux = 32'(in_p0);
            A_RISE:   rd_mux = 32'(rise_en_q);
            A_FALL:   rd_mux = 32'(fall_en_q);
            A_PEND:   rd_mux = 32'(pend_q);
            A_BLINK:  rd_mux = 32'(blink_en_q);
            A_PERIOD: rd_mux = 32'(period_q);
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q      <= '0;
            out_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            blink_en_q <= '0;
            period_q   <= '0;
        end else if (wr) begin
            case (bus_addr)
                A_DIR:    dir_q      <= N'(be_merge(32'(dir_q), bus_wr_data, bus_mask));
                A_OUT:    out_q      <= N'(be_merge(32'(out_q), bus_wr_data, bus_mask));
                A_RISE:   rise_en_q  <= N'(be_merge(32'(rise_en_q), bus_wr_data, bus_mask));
                A_FALL:   fall_en_q  <= N'(be_merge(32'(fall_en_q), bus_wr_data, bus_mask));
                A_BLINK:  blink_en_q <= N'(be_merge(32'(blink_en_q), bus_wr_data, bus_mask));
                A_PERIOD: period_q   <= BLINK_W'(be_merge(32'(period_q), bus_wr_data, bus_mask));
                default:  ;
            endcase
        end
    end

    // Bus response: ack and read data one cycle after the request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_ack     <= 1'b0;
            bus_rd_data <= '0;
        end else begin
            bus_ack     <= bus_req;
            bus_rd_data <= (bus_req && !bus_we) ? rd_mux : '0;
        end
    end

    // Input synchroniser, edge history and interrupt pending (set wins over W1C)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) in_sync[k] <= '0;
            in_p1  <= '0;
            pend_q <= '0;
            irq    <= 1'b0;
        end else begin
            in_sync[0] <= gpio_in;
            for (int k = 1; k < SYNC_STAGES; k++) in_sync[k] <= in_sync[k-1];
            in_p1  <= in_p0;
            pend_q <= (pend_q & ~pend_clr) | pend_set;
            irq    <= |pend_q;
        end
    end

    // Blink generator: half-period of PERIOD+1 cycles; phase freezes when PERIOD is 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            gpio_out <= '0;
        end else begin
            if (wr && bus_addr == A_PERIOD) begin
                cnt_q <= '0;
            end else if (period_q == '0) begin
                cnt_q <= '0;
            end else if (cnt_q == period_q) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + BLINK_W'(1);
            end
            gpio_out <= out_q ^ (blink_en_q & {N{phase_q}});
        end
    end

endmodule

// File: tb/tb_krz_gpio.sv
// Directed bench for krz_gpio: N=8 main instance plus N=32 and N=1 instances
// sharing the same bus for the width sweep.
module tb_krz_gpio;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [2:0]  bus_addr = '0;
    logic [3:0]  bus_mask = '0;
    logic [31:0] bus_wr_data = '0;
    logic [31:0] gin = '0;

    logic [31:0] rd8, rd32, rd1;
    logic        ack8, ack32, ack1;
    logic [7:0]  gout8, goe8;
    logic [31:0] gout32, goe32;
    logic [0:0]  gout1, goe1;
    logic        irq8, irq32, irq1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    krz_gpio #(.N(8), .SYNC_STAGES(2), .BLINK_W(24)) u8 (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_mask(bus_mask), .bus_wr_data(bus_wr_data), .bus_rd_data(rd8), .bus_ack(ack8),
        .gpio_in(gin[7:0]), .gpio_out(gout8), .gpio_oe(goe8), .irq(irq8));

    krz_gpio #(.N(32), .SYNC_STAGES(2), .BLINK_W(24)) u32 (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_mask(bus_mask), .bus_wr_data(bus_wr_data), .bus_rd_data(rd32), .bus_ack(ack32),
        .gpio_in(gin), .gpio_out(gout32), .gpio_oe(goe32), .irq(irq32));

    krz_gpio #(.N(1), .SYNC_STAGES(2), .BLINK_W(24)) u1 (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_mask(bus_mask), .bus_wr_data(bus_wr_data), .bus_rd_data(rd1), .bus_ack(ack1),
        .gpio_in(gin[0:0]), .gpio_out(gout1), .gpio_oe(goe1), .irq(irq1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wr_data = d; bus_mask = m;
        @(posedge clk);
        #1;
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d8,
                            output logic [31:0] d32, output logic [31:0] d1);
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = a; bus_mask = 4'hF;
        @(posedge clk);
        #1;
        bus_req = 1'b0;
        d8 = rd8; d32 = rd32; d1 = rd1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0x00000001 expected 0x00000000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d8, d32, d1;

        // Power-on reset
        cycles(3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("por_gpio_out", 32'(gout8), 32'h0);
        check("por_gpio_oe", 32'(goe8), 32'h0);
        check("por_irq", 32'(irq8), 32'h0);
        check("por_ack", 32'(ack8), 32'h0);
        check("por_rd_data", rd8, 32'h0);

        // Reset in the middle of blinking
        bus_write(3'd0, 32'hFF, 4'hF);
        bus_write(3'd1, 32'hA5, 4'hF);
        bus_write(3'd7, 32'h3, 4'hF);
        bus_write(3'd6, 32'h1, 4'hF);
        cycles(2);
        check("mid_oe_before", 32'(goe8), 32'hFF);
        check("mid_out_before", 32'(gout8) & 32'hFE, 32'hA4);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_oe", 32'(goe8), 32'h0);
        check("mid_rst_out", 32'(gout8), 32'h0);
        check("mid_rst_irq", 32'(irq8), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), d8, d32, d1);
            check($sformatf("rst_reg%0d", a), d8, 32'h0);
        end

        // Bus timing and byte masks
        bus_write(3'd1, 32'hFFFF_FF3C, 4'b0001);
        check("wr_ack", 32'(ack8), 32'h1);
        bus_read(3'd1, d8, d32, d1);
        check("rd_ack", 32'(ack8), 32'h1);
        check("rd_out8", d8, 32'h3C);
        check("rd_out32_mask", d32, 32'h3C);
        check("rd_ack32", 32'(ack32), 32'h1);
        cycles(1);
        check("idle_ack", 32'(ack8), 32'h0);
        check("idle_rd_data", rd8, 32'h0);
        check("gpio_out_3c", 32'(gout8), 32'h3C);
        bus_write(3'd2, 32'hFF, 4'hF);
        bus_read(3'd2, d8, d32, d1);
        check("in_write_ignored", d8, 32'h0);

        // Edge interrupts
        @(negedge clk);
        gin[2] = 1'b1;
        cycles(4);
        bus_write(3'd3, 32'h02, 4'hF);
        bus_write(3'd4, 32'h04, 4'hF);
        bus_read(3'd5, d8, d32, d1);
        check("pend_init", d8, 32'h0);
        @(negedge clk);
        gin[1] = 1'b1;
        cycles(3);
        check("irq_not_yet", 32'(irq8), 32'h0);
        cycles(1);
        check("irq_rise", 32'(irq8), 32'h1);
        bus_read(3'd5, d8, d32, d1);
        check("pend_rise", d8, 32'h02);
        bus_read(3'd2, d8, d32, d1);
        check("in_value", d8, 32'h06);
        @(negedge clk);
        gin[2] = 1'b0;
        cycles(5);
        bus_read(3'd5, d8, d32, d1);
        check("pend_fall", d8, 32'h06);
        bus_write(3'd5, 32'h02, 4'hF);
        bus_read(3'd5, d8, d32, d1);
        check("pend_w1c", d8, 32'h04);
        check("irq_still", 32'(irq8), 32'h1);

        // Set and W1C of the same bit in the same cycle
        @(negedge clk);
        gin[1] = 1'b0;
        cycles(5);
        bus_read(3'd5, d8, d32, d1);
        check("pend_no_fall1", d8, 32'h04);
        @(negedge clk);
        gin[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        bus_write(3'd5, 32'h02, 4'hF);
        bus_read(3'd5, d8, d32, d1);
        check("pend_set_wins", d8, 32'h06);
        bus_write(3'd5, 32'hFF, 4'hF);
        cycles(2);
        check("irq_cleared", 32'(irq8), 32'h0);

        // Blink on pin 0, period 3
        bus_write(3'd1, 32'h00, 4'hF);
        bus_write(3'd6, 32'h01, 4'hF);
        bus_write(3'd7, 32'h03, 4'hF);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("blink_k%0d", k), 32'(gout8), 32'(((k - 1) / 4) % 2));
        end
        bus_write(3'd7, 32'h0, 4'hF);
        cycles(6);
        check("blink_frozen", 32'(gout8), 32'h01);
        bus_write(3'd1, 32'h01, 4'hF);
        cycles(2);
        check("blink_xor_out", 32'(gout8), 32'h00);

        // Width sweep across N=8, N=32, N=1
        @(negedge clk);
        gin = '0;
        rst = 1'b1;
        cycles(2);
        @(negedge clk);
        rst = 1'b0;
        bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
        bus_read(3'd0, d8, d32, d1);
        check("dir_n8", d8, 32'hFF);
        check("dir_n32", d32, 32'hFFFF_FFFF);
        check("dir_n1", d1, 32'h1);
        check("oe_n32", goe32, 32'hFFFF_FFFF);
        check("oe_n1", 32'(goe1), 32'h1);
        bus_write(3'd7, 32'hFFFF_FFFF, 4'hF);
        bus_read(3'd7, d8, d32, d1);
        check("period_n8", d8, 32'h00FF_FFFF);
        check("period_n32", d32, 32'h00FF_FFFF);
        bus_write(3'd6, 32'h8000_0001, 4'hF);
        bus_write(3'd7, 32'h1, 4'hF);
        cycles(3);
        check("blink_msb_on32", gout32, 32'h8000_0001);
        check("blink_on1", 32'(gout1), 32'h1);
        check("blink_on8", 32'(gout8), 32'h01);
        cycles(2);
        check("blink_msb_off32", gout32, 32'h0);
        check("blink_off1", 32'(gout1), 32'h0);
        bus_write(3'd6, 32'h0, 4'hF);
        bus_write(3'd7, 32'h0, 4'hF);
        bus_write(3'd3, 32'h8000_0001, 4'hF);
        @(negedge clk);
        gin = 32'h8000_0001;
        cycles(5);
        check("irq_msb32", 32'(irq32), 32'h1);
        check("irq_n1", 32'(irq1), 32'h1);
        bus_read(3'd5, d8, d32, d1);
        check("pend_n32", d32, 32'h8000_0001);
        check("pend_n8", d8, 32'h01);
        check("pend_n1", d1, 32'h1);
        check("ack_n1", 32'(ack1), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
